rx_byte_fifo: RTL and testbench

Byte buffer directly downstream of `uart_rx` in the console mux. It detects each new byte announced on the receiver's `ready` level and pushes the byte into a power-of-two circular FIFO. It presents buffered bytes to the mux arbiter over a first-word-fall-through valid/ready interface. It also reports fill level and a sticky overflow flag.

---
 rtl/rx_byte_fifo_if.sv | 29 ++
 rtl/rx_byte_fifo.sv | 86 ++++++++
 tb/tb_rx_byte_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rx_byte_fifo_if.sv
// rx_byte_fifo_if -- the byte-buffer's bus signals.
//   Receiver side: rx_ready (uart_rx ready level) and rx_data.
//   Consumer side: out_valid/out_ready/out_data, which is a first-word-fall-through handshake.
//   Status: count (0..2^DEPTH_LOG2), sticky overflow, and clear_overflow.
// Modports:
//   master -- the environment: uart_rx plus the mux arbiter.
//   slave  -- the FIFO itself.
interface rx_byte_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  rx_ready;
   logic [7:0]            rx_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [7:0]            out_data;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;
   logic                  clear_overflow;

   modport master (
      output rx_ready, rx_data, out_ready, clear_overflow,
      input  out_valid, out_data, count, overflow
   );

   modport slave (
      input  rx_ready, rx_data, out_ready, clear_overflow,
      output out_valid, out_data, count, overflow
   );
endinterface

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo -- byte buffer behind uart_rx in the console mux.
// A new byte is detected on each rising edge of the receiver's ready level.
// Each detected byte is pushed into a 2^DEPTH_LOG2-entry circular FIFO.
// Bytes are presented first-word-fall-through to the arbiter.
// Ports:
//   clk -- rising-edge clock.
//   rst -- asynchronous, active-high reset.
//   bus -- rx_byte_fifo_if.slave. Carries rx_ready/rx_data, out_valid/out_ready/out_data,
//          count, overflow and clear_overflow.
// Build option:
//   RX_FIFO_OVERWRITE_EN -- when defined, a push into a full FIFO (with no pop)
//   evicts the oldest byte. When undefined, the incoming byte is dropped.
//   In both cases overflow is set.
module rx_byte_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic           clk,
   input  logic           rst,
   rx_byte_fifo_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PTR_W = DEPTH_LOG2 + 1;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             rx_ready_d;
   logic             overflow_q;

   logic push;
   logic pop;
   logic empty;
   logic full;
   logic wr_adv;
   logic rd_adv;
   logic ovf_set;

   // rx_ready_d comes out of reset high.
   // A level that is already high at release is therefore not seen as a new byte.
   assign push  = bus.rx_ready & ~rx_ready_d;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign pop   = ~empty & bus.out_ready;

   // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
   assign ovf_set = push & full & ~pop;

`ifdef RX_FIFO_OVERWRITE_EN
   // The overflowing write lands in the oldest slot.
   // Advancing rd_ptr together with wr_ptr evicts that oldest byte.
   assign wr_adv = push;
   assign rd_adv = pop | ovf_set;
`else
   assign wr_adv = push & ~ovf_set;
   assign rd_adv = pop;
`endif

   assign bus.out_valid = ~empty;
   assign bus.out_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];
   assign bus.count     = wr_ptr - rd_ptr;
   assign bus.overflow  = overflow_q;

   // Control state: pointers, edge detector, sticky flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rx_ready_d <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         rx_ready_d <= bus.rx_ready;
         if (wr_adv) wr_ptr <= wr_ptr + 1'b1;
         if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
         if (ovf_set)
            overflow_q <= 1'b1;
         else if (bus.clear_overflow)
            overflow_q <= 1'b0;
      end
   end

   // Storage array: data only, not reset.
   always_ff @(posedge clk) begin
      if (wr_adv) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.rx_data;
   end
endmodule

// File: tb/tb_rx_byte_fifo.sv
module tb_rx_byte_fifo;
   localparam int DL    = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rx_byte_fifo_if #(.DEPTH_LOG2(DL)) bus ();
   rx_byte_fifo #(.DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of stored bytes.
   // It also keeps the previous rx_ready level and the sticky flag.
   logic [7:0] m_q[$];
   bit         m_prev = 1'b1;
   bit         m_ovf  = 1'b0;

   task automatic model_reset();
      m_q.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
   endtask

   // Applies the spec's rules to the inputs present at a clock edge.
   task automatic model_edge();
      bit       p_push;
      bit       p_pop;
      logic [7:0] tmp;
      p_push = bus.rx_ready && !m_prev;
      p_pop  = (m_q.size() != 0) && bus.out_ready;
      if (p_push && m_q.size() == DEPTH && !p_pop) begin
         m_ovf = 1'b1;
`ifdef RX_FIFO_OVERWRITE_EN
         tmp = m_q.pop_front();
         m_q.push_back(bus.rx_data);
`endif
      end else begin
         if (bus.clear_overflow) m_ovf = 1'b0;
         if (p_pop) tmp = m_q.pop_front();
         if (p_push) m_q.push_back(bus.rx_data);
      end
      m_prev = bus.rx_ready;
   endtask

   task automatic tick(input logic r, input logic [7:0] d, input logic o, input logic c);
      bus.rx_ready       = r;
      bus.rx_data        = d;
      bus.out_ready      = o;
      bus.clear_overflow = c;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d);
      tick(1'b1, d, 1'b0, 1'b0);
      tick(1'b0, d, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.rx_ready = 1'b0; bus.rx_data = 8'h00; bus.out_ready = 1'b0; bus.clear_overflow = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
      rst = 1'b0;
      model_reset();
      tick(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_single_push();
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 8'h41, 1'b0, 1'b0);
         checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL hold_count cyc %0d got %0d want 1", i, bus.count); end
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h41) begin
            errors++; $display("FAIL hold_data cyc %0d got v=%b d=%h want v=1 d=41", i, bus.out_valid, bus.out_data); end
      end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL hold_drain got %0d want 0", bus.count); end
   endtask

   task automatic test_drain_order();
      push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.count !== 3'(3 - i) || bus.out_data !== 8'(i + 1)) begin
            errors++; $display("FAIL drain_seq %0d got c=%0d d=%h want c=%0d d=%h", i, bus.count, bus.out_data, 3 - i, i + 1); end
         tick(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL drain_end got c=%0d v=%b want c=0 v=0", bus.count, bus.out_valid); end
   endtask

   task automatic test_overflow();
      int peak = 0;
      logic [7:0] base;
`ifdef RX_FIFO_OVERWRITE_EN
      base = 8'h11;
`else
      base = 8'h10;
`endif
      for (int i = 0; i < 5; i++) begin
         push_byte(8'(8'h10 + i));
         if (int'(bus.count) > peak) peak = int'(bus.count);
      end
      checks++; if (peak != 4) begin errors++; $display("FAIL ovf_peak got %0d want 4", peak); end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.out_data !== 8'(base + i)) begin
            errors++; $display("FAIL ovf_data %0d got %h want %h", i, bus.out_data, 8'(base + i)); end
         tick(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", bus.out_valid); end
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", bus.overflow); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 4; i++) push_byte(8'(8'h20 + i));
      tick(1'b1, 8'h55, 1'b1, 1'b0);
      checks++; if (bus.count !== 3'd4 || bus.overflow !== 1'b0) begin
         errors++; $display("FAIL fpp_state got c=%0d o=%b want c=4 o=0", bus.count, bus.overflow); end
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.out_data !== ((i == 3) ? 8'h55 : 8'(8'h21 + i))) begin
            errors++; $display("FAIL fpp_data %0d got %h", i, bus.out_data); end
         tick(1'b0, 8'h00, 1'b1, 1'b0);
      end
   endtask

   task automatic test_clear_priority();
      for (int i = 0; i < 4; i++) push_byte(8'(8'h30 + i));
      tick(1'b1, 8'h99, 1'b0, 1'b1);
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr_prio got %b want 1", bus.overflow); end
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_next got %b want 0", bus.overflow); end
      while (m_q.size() != 0) begin
         checks++; if (bus.out_data !== m_q[0]) begin
            errors++; $display("FAIL clr_data got %h want %h", bus.out_data, m_q[0]); end
         tick(1'b0, 8'h00, 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset_ready_high();
      bus.rx_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) tick(1'b1, 8'h77, 1'b0, 1'b0);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rhigh_nopush got %0d want 0", bus.count); end
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 8'h78, 1'b0, 1'b0);
      checks++; if (bus.count !== 3'd1 || bus.out_data !== 8'h78) begin
         errors++; $display("FAIL rhigh_push got c=%0d d=%h want c=1 d=78", bus.count, bus.out_data); end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      push_byte(8'hA1); push_byte(8'hA2);
      rst = 1'b1;
      #2;
      checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL async_rst got c=%0d v=%b want c=0 v=0", bus.count, bus.out_valid); end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      tick(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      logic [7:0] sent[$];
      logic [7:0] got[$];
      logic [7:0] d;
      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom);
         sent.push_back(d);
         for (int ph = 0; ph < 2; ph++) begin
            if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
            tick(ph == 0, d, 1'b1, 1'b0);
            checks++; if (bus.count > 3'd4) begin errors++; $display("FAIL wrap_count got %0d max 4", bus.count); end
         end
      end
      checks++; if (got.size() != 20) begin errors++; $display("FAIL wrap_n got %0d want 20", got.size()); end
      for (int i = 0; i < 20 && i < got.size(); i++) begin
         checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL wrap_data %0d got %h want %h", i, got[i], sent[i]); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
         checks++; if (bus.count !== 3'(m_q.size()) || bus.out_valid !== (m_q.size() != 0)) begin
            errors++; $display("FAIL rnd_count cyc %0d got c=%0d v=%b want c=%0d", i, bus.count, bus.out_valid, m_q.size()); end
         checks++; if (bus.overflow !== m_ovf) begin
            errors++; $display("FAIL rnd_ovf cyc %0d got %b want %b", i, bus.overflow, m_ovf); end
         if (m_q.size() != 0) begin
            checks++; if (bus.out_data !== m_q[0]) begin
               errors++; $display("FAIL rnd_data cyc %0d got %h want %h", i, bus.out_data, m_q[0]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_drain_order();
      test_overflow();
      test_full_push_pop();
      test_clear_priority();
      test_reset_ready_high();
      test_async_reset();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
